// File: rtl/fetch_stage_if.sv
// fetch_stage_if: request/done read channel between the fetch stage and a
// multi-cycle instruction memory. The fetch stage is the master: it drives
// the read strobe and address, and the memory returns a word with a done flag.
interface fetch_stage_if;
  logic        mem_rd;    // one-cycle read request
  logic [15:0] mem_addr;  // read address (current PC)
  logic [15:0] mem_data;  // returned instruction word, valid with mem_done
  logic        mem_done;  // read complete

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_data,
    input  mem_done
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_data,
    output mem_done
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding Decode.
// Owns the PC, issues one read at a time to a multi-cycle instruction memory
// over fetch_stage_if, and holds the IF/ID register (instruction, PC+2, valid).
// Honours Stall from hazard logic, flushes on Redirect from Execute and parks
// once a HALT word (opcode bits [15:11] all zero) has been loaded into IF/ID.
// Optional build macro FETCH_ALIGN_CHECK_EN: adds a sticky err_o flag raised by
// a redirect to an odd address, which also parks the stage without fetching.
// Without the macro, bit 0 of the redirect target is cleared on load.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [15:0]   redirect_pc_i,
  fetch_stage_if.master mem,
  output logic [15:0]   instruction_o,
  output logic [15:0]   pc2_o,
  output logic          valid_o,
  output logic          halted_o
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic          err_o
`endif
);

  typedef enum logic [1:0] {
    ST_ISSUE  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // A HALT is any word whose opcode field [15:11] is zero.
  function automatic logic is_halt(input logic [15:0] word);
    return (word[15:11] == 5'b00000);
  endfunction

  // Sequential PC step; wraps modulo 2^16 with no flag.
  function automatic logic [15:0] pc_step(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc2_q, pc2_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] pend_q, pend_d;
  logic        squash_q, squash_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        err_q, err_d;
`endif

  logic        load_s;        // a word enters IF/ID this cycle
  logic [15:0] load_word_s;   // the word being loaded
  state_e      redir_state_s; // where a clean redirect sends the FSM
  logic        redir_squash_s;// redirect leaves a read in flight to be dropped

  // Read request: only from ISSUE, suppressed by a same-cycle redirect and by reset.
  assign mem.mem_rd   = (state_q == ST_ISSUE) & ~redirect_i & ~rst;
  assign mem.mem_addr = pc_q;

  assign instruction_o = instr_q;
  assign pc2_o         = pc2_q;
  assign valid_o       = valid_q;
  assign halted_o      = halted_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign err_o         = err_q;
`endif

  // Next-state logic for the fetch FSM, PC and the IF/ID register.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    pc2_d          = pc2_q;
    valid_d        = valid_q;
    halted_d       = halted_q;
    pend_d         = pend_q;
    squash_d       = squash_q;
`ifdef FETCH_ALIGN_CHECK_EN
    err_d          = err_q;
`endif
    load_s         = 1'b0;
    load_word_s    = pend_q;
    redir_state_s  = ST_ISSUE;
    redir_squash_s = 1'b0;

    // A redirect in WAIT with the read still outstanding must drop its return;
    // if the return arrives in the same cycle it is simply the dropped word.
    if ((state_q == ST_WAIT) && !mem.mem_done) begin
      redir_state_s  = ST_WAIT;
      redir_squash_s = 1'b1;
    end else begin
      redir_state_s  = ST_ISSUE;
      redir_squash_s = 1'b0;
    end

    if (redirect_i) begin
      // Flush has priority over stall, memory return and every state.
      instr_d  = NOP_INSTR;
      pc2_d    = 16'h0000;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      pend_d   = 16'h0000;
`ifdef FETCH_ALIGN_CHECK_EN
      pc_d = redirect_pc_i;
      if (redirect_pc_i[0]) begin
        // Misaligned target: park without fetching; any in-flight return is ignored in HALTED.
        err_d    = 1'b1;
        halted_d = 1'b1;
        state_d  = ST_HALTED;
        squash_d = 1'b0;
      end else begin
        state_d  = redir_state_s;
        squash_d = redir_squash_s;
      end
`else
      pc_d     = redirect_pc_i & 16'hFFFE;
      state_d  = redir_state_s;
      squash_d = redir_squash_s;
`endif
    end else begin
      case (state_q)
        ST_ISSUE: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (mem.mem_done) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = ST_ISSUE;
            end else if (!stall_i || !valid_q) begin
              load_s      = 1'b1;
              load_word_s = mem.mem_data;
            end else begin
              // Decode is stalled on a real instruction: park the word.
              pend_d  = mem.mem_data;
              state_d = ST_HOLD;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            load_s      = 1'b1;
            load_word_s = pend_q;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_ISSUE;
        end
      endcase

      if (load_s) begin
        instr_d = load_word_s;
        pc2_d   = pc_step(pc_q);
        valid_d = 1'b1;
        pc_d    = pc_step(pc_q);
        if (is_halt(load_word_s)) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          state_d  = ST_ISSUE;
        end
      end else if (!stall_i) begin
        // Decode consumed IF/ID and nothing new arrived: present a bubble.
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end else begin
        // Decode stalled and no new word: IF/ID holds.
        valid_d = valid_q;
        instr_d = instr_q;
      end
    end
  end

  // State register for the FSM, PC, IF/ID register, pend buffer and squash flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ISSUE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc2_q    <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      pend_q   <= 16'h0000;
      squash_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc2_q    <= pc2_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      pend_q   <= pend_d;
      squash_q <= squash_d;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed tests for fetch_stage with a latency-2 memory model.
// Expected IF/ID loads are queued per test; a monitor pops one entry each time
// a new word appears in IF/ID and compares it.
module tb_fetch_stage;
  localparam int LAT = 2;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] pc2;
  logic        valid;
  logic        halted;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        err;
`endif

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [15:0] rd_log[$];

  fetch_stage_if mif();

  fetch_stage #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0800)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .mem          (mif),
    .instruction_o(instr),
    .pc2_o        (pc2),
    .valid_o      (valid),
    .halted_o     (halted)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .err_o        (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h4000;
      16'h0002: return 16'h4100;
      16'h0004: return 16'h0000;
      16'h0100: return 16'h4200;
      16'h0102: return 16'h0000;
      16'hFFFE: return 16'h4300;
      default:  return 16'h4800;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input logic [15:0] i, input logic [15:0] p);
    exp_t e;
    e.instr = i;
    e.pc2   = p;
    exp_q.push_back(e);
  endtask

  // Memory model: sees a request just after the falling edge, answers LAT cycles later.
  initial begin : responder
    int          cnt;
    logic [15:0] addr;
    cnt = 0;
    addr = 16'h0000;
    mif.mem_done = 1'b0;
    mif.mem_data = 16'h0000;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        cnt = 0;
        mif.mem_done = 1'b0;
      end else begin
        mif.mem_done = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mif.mem_done = 1'b1;
            mif.mem_data = mem_word(addr);
          end
        end
        if (mif.mem_rd) begin
          addr = mif.mem_addr;
          cnt  = LAT;
          rd_log.push_back(mif.mem_addr);
        end
      end
    end
  end

  // Monitor: a new IF/ID word is present when valid rises or the previous one was consumed.
  initial begin : monitor
    logic vprev;
    exp_t e;
    vprev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        vprev = 1'b0;
      end else begin
        if (valid && (!vprev || !stall)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got instr=%h pc2=%h with nothing expected", instr, pc2);
          end else begin
            e = exp_q.pop_front();
            if (instr !== e.instr || pc2 !== e.pc2) begin
              errors++;
              $display("FAIL sb_word: got instr=%h pc2=%h expected instr=%h pc2=%h",
                       instr, pc2, e.instr, e.pc2);
            end
          end
        end
        vprev = valid;
      end
    end
  end

  task automatic do_reset(input string name);
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    repeat (2) @(negedge clk);
    chk({name, "_rst_instr"}, instr, 16'h0800);
    chk({name, "_rst_pc2"}, pc2, 16'h0000);
    chk({name, "_rst_valid"}, valid, 1'b0);
    chk({name, "_rst_halted"}, halted, 1'b0);
    chk({name, "_rst_mem_rd"}, mif.mem_rd, 1'b0);
    chk({name, "_rst_addr"}, mif.mem_addr, 16'h0000);
    exp_q.delete();
    rd_log.delete();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!valid && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!valid) begin
      errors++;
      $display("FAIL %s_valid_timeout: valid=%b after %0d cycles, expected 1", name, valid, n);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!mif.mem_done && n < budget);
    checks++;
    if (!mif.mem_done) begin
      errors++;
      $display("FAIL %s_done_timeout: mem_done=%b after %0d cycles, expected 1", name, mif.mem_done, n);
    end
  endtask

  // Wait for the park on HALT, then confirm no further reads and a bubble in IF/ID.
  task automatic finish_test(input string name, input int budget);
    int n;
    int rd_before;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!halted) begin
      errors++;
      $display("FAIL %s_halt_timeout: halted=%b after %0d cycles, expected 1", name, halted, n);
    end
    rd_before = rd_log.size();
    repeat (6) @(posedge clk);
    #1;
    chk({name, "_no_rd_after_halt"}, rd_log.size(), rd_before);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_bubble_valid"}, valid, 1'b0);
    chk({name, "_bubble_instr"}, instr, 16'h0800);
    chk({name, "_still_halted"}, halted, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;

    // Test 1: straight-line fetch to HALT.
    do_reset("t1");
    push_exp(16'h4000, 16'h0002);
    push_exp(16'h4100, 16'h0004);
    push_exp(16'h0000, 16'h0006);
    finish_test("t1", 60);
    chk("t1_rd_count", rd_log.size(), 3);
    chk("t1_pc_after_halt", mif.mem_addr, 16'h0006);

    // Test 2: stall while the second word returns.
    do_reset("t2");
    push_exp(16'h4000, 16'h0002);
    push_exp(16'h4100, 16'h0004);
    push_exp(16'h0000, 16'h0006);
    wait_valid("t2", 20);
    @(negedge clk);
    stall = 1'b1;
    repeat (5) @(negedge clk);
    chk("t2_hold_instr", instr, 16'h4000);
    chk("t2_hold_valid", valid, 1'b1);
    chk("t2_hold_no_rd", mif.mem_rd, 1'b0);
    chk("t2_hold_rd_count", rd_log.size(), 2);
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk("t2_release_instr", instr, 16'h4100);
    chk("t2_release_pc2", pc2, 16'h0004);
    finish_test("t2", 60);
    chk("t2_one_rd_per_addr", rd_log.size(), 3);

    // Test 3: redirect while a read is outstanding; its return is dropped.
    do_reset("t3");
    push_exp(16'h4200, 16'h0102);
    push_exp(16'h0000, 16'h0104);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    @(negedge clk);
    chk("t3_flush_valid", valid, 1'b0);
    chk("t3_flush_addr", mif.mem_addr, 16'h0100);
    chk("t3_wait_no_rd", mif.mem_rd, 1'b0);
    redirect = 1'b0;
    @(posedge clk);
    #1;
    chk("t3_refetch_addr", mif.mem_addr, 16'h0100);
    chk("t3_refetch_rd", mif.mem_rd, 1'b1);
    chk("t3_refetch_valid", valid, 1'b0);
    finish_test("t3", 60);
    chk("t3_rd_count", rd_log.size(), 3);

    // Test 4: redirect in the same cycle as stall and a memory return.
    do_reset("t4");
    push_exp(16'h4000, 16'h0002);
    push_exp(16'h4200, 16'h0102);
    push_exp(16'h0000, 16'h0104);
    wait_valid("t4", 20);
    @(negedge clk);
    stall = 1'b1;
    wait_done("t4", 10);
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    @(posedge clk);
    #1;
    chk("t4_flush_valid", valid, 1'b0);
    chk("t4_flush_instr", instr, 16'h0800);
    chk("t4_flush_pc2", pc2, 16'h0000);
    chk("t4_flush_addr", mif.mem_addr, 16'h0100);
    @(negedge clk);
    redirect = 1'b0;
    stall = 1'b0;
    #1;
    chk("t4_issue_rd", mif.mem_rd, 1'b1);
    finish_test("t4", 60);
    chk("t4_rd_count", rd_log.size(), 4);

    // Test 5: redirect to the top of memory; PC wraps to zero.
    do_reset("t5");
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    push_exp(16'h4300, 16'h0000);
    push_exp(16'h4000, 16'h0002);
    push_exp(16'h4100, 16'h0004);
    push_exp(16'h0000, 16'h0006);
    @(negedge clk);
    redirect = 1'b0;
    finish_test("t5", 80);
    chk("t5_rd_count", rd_log.size(), 4);
    if (rd_log.size() >= 2) begin
      chk("t5_first_addr", rd_log[0], 16'hFFFE);
      chk("t5_wrap_addr", rd_log[1], 16'h0000);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Test 6: misaligned redirect raises err and parks.
    do_reset("t6");
    chk("t6_err_reset", err, 1'b0);
    redirect = 1'b1;
    redirect_pc = 16'h0011;
    @(negedge clk);
    redirect = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_err", err, 1'b1);
    chk("t6_halted", halted, 1'b1);
    chk("t6_no_rd", mif.mem_rd, 1'b0);
    chk("t6_rd_count", rd_log.size(), 0);
`else
    // Test 6: odd redirect target has bit 0 cleared.
    do_reset("t6");
    redirect = 1'b1;
    redirect_pc = 16'h0101;
    push_exp(16'h4200, 16'h0102);
    push_exp(16'h0000, 16'h0104);
    @(negedge clk);
    redirect = 1'b0;
    chk("t6_aligned_addr", mif.mem_addr, 16'h0100);
    finish_test("t6", 60);
    chk("t6_rd_count", rd_log.size(), 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
